// File: rtl/data_consolidation_p.sv
// data_consolidation_p
//
// Packs a stream of DIN_W-bit symbols into DIN_W*RATIO-bit words and queues
// the words in a small first-word-fall-through FIFO.
//
// Handshakes (valid/ready):
//   input side : a symbol transfers on a rising edge where din_en && din_rdy;
//                a flush transfers on a rising edge where flush && din_rdy.
//                din_rdy is registered from the FIFO level, so it depends
//                only on state and never combinationally on dout_rdy.
//   output side: the head word transfers on a rising edge where
//                dout_en && dout_rdy. dout/dout_cnt hold steady while
//                dout_en=1 and dout_rdy=0.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   din        input symbol (DIN_W bits)
//   din_en     symbol valid
//   flush      emit the partial word currently being packed
//   din_rdy    1 when the output FIFO is not full (registered)
//   dout       FIFO head word (0 when empty)
//   dout_cnt   number of valid symbols in dout (1..RATIO, 0 when empty)
//   dout_en    FIFO not empty
//   dout_rdy   consumer ready
//   ovf        sticky: a symbol arrived while din_rdy=0 and was dropped
module data_consolidation_p #(
    parameter int DIN_W     = 2,
    parameter int RATIO     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter int DEPTH     = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DIN_W-1:0]                 din,
    input  logic                             din_en,
    input  logic                             flush,
    output logic                             din_rdy,
    output logic [DIN_W*RATIO-1:0]           dout,
    output logic [$clog2(RATIO+1)-1:0]       dout_cnt,
    output logic                             dout_en,
    input  logic                             dout_rdy,
    output logic                             ovf
);

    localparam int DOUT_W = DIN_W * RATIO;
    localparam int CNT_W  = $clog2(RATIO);
    localparam int DCNT_W = $clog2(RATIO + 1);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = $clog2(DEPTH + 1);

    // Packer state
    logic [DOUT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // FIFO state
    logic [DOUT_W-1:0] word_mem_q [DEPTH];
    logic [DOUT_W-1:0] word_mem_d [DEPTH];
    logic [DCNT_W-1:0] cnt_mem_q  [DEPTH];
    logic [DCNT_W-1:0] cnt_mem_d  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              din_rdy_q, din_rdy_d;
    logic              ovf_q, ovf_d;

    // Datapath intermediates
    logic              accept_sym;
    logic              accept_flush;
    logic              full_word;
    logic              push;
    logic              pop;
    logic              not_empty;
    logic [DOUT_W-1:0] acc_ins;
    logic [DCNT_W-1:0] cnt_ins;

    assign accept_sym   = din_en && din_rdy_q;
    assign accept_flush = flush && din_rdy_q;
    assign not_empty    = (level_q != '0);
    assign pop          = not_empty && dout_rdy;

    // Packer: the incoming symbol is inserted first, so a flush on the same
    // edge sees it. cnt_ins is one bit wider than cnt so it can reach RATIO,
    // which makes it directly usable as the pushed word's symbol count.
    always_comb begin
        acc_ins   = acc_q;
        cnt_ins   = DCNT_W'(cnt_q) + DCNT_W'(accept_sym);
        full_word = accept_sym && (cnt_q == CNT_W'(RATIO - 1));
        if (accept_sym) begin
            for (int k = 0; k < RATIO; k++) begin
                if (cnt_q == CNT_W'(k)) begin
                    if (MSB_FIRST) begin
                        acc_ins[(RATIO - 1 - k) * DIN_W +: DIN_W] = din;
                    end else begin
                        acc_ins[k * DIN_W +: DIN_W] = din;
                    end
                end
            end
        end
        // Flush with nothing packed is a no-op: zero-length words never leave.
        push = full_word || (accept_flush && (cnt_ins != '0));
        if (push) begin
            acc_d = '0;
            cnt_d = '0;
        end else begin
            acc_d = acc_ins;
            cnt_d = CNT_W'(cnt_ins);
        end
    end

    // FIFO bookkeeping. Pushes only happen while din_rdy_q=1 (not full), so
    // no overflow check is needed on the write side.
    always_comb begin
        word_mem_d = word_mem_q;
        cnt_mem_d  = cnt_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) begin
            word_mem_d[wr_ptr_q] = acc_ins;
            cnt_mem_d[wr_ptr_q]  = cnt_ins;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        level_d   = level_q + LVL_W'(push) - LVL_W'(pop);
        din_rdy_d = (level_d != LVL_W'(DEPTH));
        ovf_d     = ovf_q || (din_en && !din_rdy_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            din_rdy_q <= 1'b1;
            ovf_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                word_mem_q[i] <= '0;
                cnt_mem_q[i]  <= '0;
            end
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            din_rdy_q  <= din_rdy_d;
            ovf_q      <= ovf_d;
            word_mem_q <= word_mem_d;
            cnt_mem_q  <= cnt_mem_d;
        end
    end

    assign din_rdy  = din_rdy_q;
    assign dout_en  = not_empty;
    assign dout     = not_empty ? word_mem_q[rd_ptr_q] : '0;
    assign dout_cnt = not_empty ? cnt_mem_q[rd_ptr_q] : '0;
    assign ovf      = ovf_q;

endmodule

// File: doc/data_consolidation_p.md
# data_consolidation_p

Parametrised successor to the fixed 2-bit-to-8-bit data consolidation block. Packs a stream of DIN_W-bit symbols into DIN_W*RATIO-bit words with selectable symbol order. Supports an explicit flush of partial words and a first-word-fall-through output FIFO with ready/valid backpressure. Sits between a narrow serial-symbol source and a wide word-oriented consumer in the data processing path.

## Interface
- DIN_W, 2, symbol width in bits (≥1)
- RATIO, 4, symbols per output word (≥2); DOUT_W = DIN_W*RATIO
- MSB_FIRST, 1, 1: first symbol lands in the top DIN_W bits; 0: first symbol lands in bits [DIN_W-1:0]
- DEPTH, 4, output FIFO depth in words (power of 2, ≥2)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- din  in  DIN_W  input symbol
- din_en  in  1  symbol valid; accepted on an edge where din_en && din_rdy
- flush  in  1  emit partial word; accepted on an edge where flush && din_rdy
- din_rdy  out  1  registered; 1 when FIFO is not full
- dout  out  DOUT_W  FIFO head word
- dout_cnt  out  clog2(RATIO+1)  valid symbols in dout (1..RATIO)
- dout_en  out  1  FIFO not empty
- dout_rdy  in  1  consumer ready; pop on an edge where dout_en && dout_rdy
- ovf  out  1  sticky; a symbol was dropped

## Operation
- Packer state:
  - Partial word register `acc`, width DOUT_W.
  - Symbol counter `cnt`, range 0..RATIO-1.
- Symbol placement: symbol index k (0-based within a word) goes to bits [(RATIO-1-k)*DIN_W +: DIN_W] when MSB_FIRST=1, and to [k*DIN_W +: DIN_W] when MSB_FIRST=0. Unfilled positions are 0.
- Accept when cnt<RATIO-1: write the symbol into acc and increment cnt.
- Accept when cnt==RATIO-1:
  - Push the completed word (acc plus this symbol) with dout_cnt=RATIO.
  - Clear acc to 0 and cnt to 0 in the same edge.
- Accepted flush with cnt>0:
  - Push acc with dout_cnt=cnt.
  - Clear acc and cnt.
- Accepted flush with cnt==0: no-op. Zero-length words are never emitted.
- Flush and symbol accepted on the same edge: the symbol is included first.
  - If that symbol completes the word, exactly one full word is pushed.
  - Otherwise, a partial word with cnt+1 symbols is pushed.
- din_en while din_rdy=0: the symbol is dropped and ovf is set; ovf clears only on rst.
- flush while din_rdy=0: ignored. The upstream holds flush until din_rdy.
- FIFO behaviour:
  - Push and pop on the same edge leave the level unchanged.
  - Pop on an empty FIFO is impossible, because pop is gated by dout_en.
  - Pointers wrap modulo DEPTH.
- Full FIFO: din_rdy=0 even if a pop occurs on the same edge, because din_rdy is registered from the level. This adds no combinational dout_rdy→din_rdy path.
- Stall while the FIFO is not full: a symbol that does not complete a word is still accepted only while din_rdy=1 (conservative rule, single condition).

## Timing
- Reset values:
  - acc=0, cnt=0, FIFO empty.
  - dout=0, dout_cnt=0, dout_en=0, din_rdy=1, ovf=0.
- Reset asserted mid-word or with a non-empty FIFO: all state is discarded and no word is emitted.
- Latency: the last symbol accepted at edge N gives dout_en=1 with the word on dout after edge N, provided the FIFO was empty. Same for an accepted flush.
- Throughput: one symbol per clock sustained with dout_rdy=1, giving one word per RATIO clocks.
- dout and dout_cnt are stable while dout_en=1 and dout_rdy=0.
- din_rdy update timing:
  - Falls after the edge that pushes the DEPTH-th word.
  - Rises after the first edge that pops from full.

## Test plan
- Stream test (defaults, MSB_FIRST=1):
  - Stimulus: symbols 3,0,2,1 on consecutive cycles, dout_rdy=1.
  - Required: dout=8'hC9, dout_cnt=4, dout_en high for exactly 1 cycle starting the cycle after the 4th accept.
  - Continuing with 40 random symbols must produce 10 words, each equal to the shift-register model {prev[5:0],din}.
- Symbol order (MSB_FIRST=0, same symbols 3,0,2,1): required dout=8'h63, dout_cnt=4.
- Partial flush:
  - MSB_FIRST=1: symbols 3,0, then flush → dout=8'hC0, dout_cnt=2, cnt back to 0.
  - MSB_FIRST=0: same stimulus → dout=8'h03.
  - A second flush with cnt==0 produces no word.
- Flush with completing symbol: symbols 1,1,1, then symbol 2 with flush on the same cycle → exactly one word 8'h56, dout_cnt=4, no extra word.
- Backpressure (DEPTH=4):
  - Stimulus: dout_rdy=0, 20 symbols at din_en=1.
  - Required: din_rdy=0 after the 16th accept; symbols 17–20 dropped; ovf=1.
  - Then dout_rdy=1: 4 words pop in order, one per cycle, din_rdy returns high the cycle after the first pop, and ovf stays 1.
- Reset mid-operation: assert rst asynchronously with 2 symbols in acc and 2 words queued → all outputs at reset values immediately; after release, a fresh 4-symbol sequence yields a correct word.
